// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC generator, imem request/response handshake and in-order fetch queue.
// Optional macro FETCH_PERF_EN adds saturating enqueue/discard counters and their ports.
module fetch_queue_unit #(
  parameter int          XLEN     = 64,
  parameter int          ILEN     = 32,
  parameter int          QDEPTH   = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_i_flush,
  input  logic [XLEN-1:0] ctrl_i_redirect_pc,
  output logic            fetch_o_imem_req_valid,
  input  logic            imem_i_req_ready,
  output logic [XLEN-1:0] fetch_o_imem_req_addr,
  input  logic            imem_i_rsp_valid,
  input  logic [ILEN-1:0] imem_i_rsp_data,
  output logic            fetch_o_valid,
  input  logic            decode_i_ready,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [ILEN-1:0] fetch_o_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_o_perf_fetched,
  output logic [31:0]     fetch_o_perf_dropped
`endif
);

  // Handshakes: a request transfers on a cycle where fetch_o_imem_req_valid && imem_i_req_ready;
  // a head entry transfers on fetch_o_valid && decode_i_ready; responses are never back-pressured.
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [XLEN-1:0] PC_RST = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occ;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [XLEN-1:0] pc_mem    [QDEPTH];
  logic [ILEN-1:0] instr_mem [QDEPTH];

  logic [CW:0]     used;
  logic [XLEN-1:0] flush_pc;
  logic            req_fire;
  logic            rsp_take;
  logic            enq;
  logic            drop_now;
  logic            pop;

  // Credits exclude responses already doomed to be dropped; out_cnt is also capped so
  // repeated flushes with a stalled imem cannot overflow the outstanding counter.
  assign used     = {1'b0, occ} + {1'b0, out_cnt} - {1'b0, drop_cnt};
  assign flush_pc = ctrl_i_redirect_pc & ~XLEN'(3);

  assign fetch_o_imem_req_valid = rst && !ctrl_i_flush && (used < (CW+1)'(QDEPTH))
                                  && (out_cnt < CW'(QDEPTH));
  assign fetch_o_imem_req_addr  = pc_q;

  assign req_fire = fetch_o_imem_req_valid && imem_i_req_ready;
  assign rsp_take = imem_i_rsp_valid && (out_cnt != '0);
  assign drop_now = rsp_take && (ctrl_i_flush || (drop_cnt != '0));
  assign enq      = rsp_take && !ctrl_i_flush && (drop_cnt == '0);

  assign fetch_o_valid = (occ != '0) && !ctrl_i_flush;
  assign pop           = fetch_o_valid && decode_i_ready;
  assign fetch_o_pc    = pc_mem[head];
  assign fetch_o_instr = instr_mem[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= PC_RST;
      rsp_pc   <= PC_RST;
      out_cnt  <= '0;
      drop_cnt <= '0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (ctrl_i_flush) begin
      // Every request still in flight after this cycle predates the redirect.
      pc_q     <= flush_pc;
      rsp_pc   <= flush_pc;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      out_cnt  <= out_cnt - CW'(rsp_take);
      drop_cnt <= out_cnt - CW'(rsp_take);
    end else begin
      if (req_fire) pc_q <= pc_q + STEP;
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_take);
      if (drop_now) drop_cnt <= drop_cnt - CW'(1);
      if (enq) begin
        pc_mem[tail]    <= rsp_pc;
        instr_mem[tail] <= imem_i_rsp_data;
        tail            <= tail + PW'(1);
        rsp_pc          <= rsp_pc + STEP;
      end
      if (pop) head <= head + PW'(1);
      occ <= occ + CW'(enq) - CW'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_o_perf_fetched <= '0;
      fetch_o_perf_dropped <= '0;
    end else begin
      if (enq && (fetch_o_perf_fetched != '1)) fetch_o_perf_fetched <= fetch_o_perf_fetched + 32'd1;
      if (drop_now && (fetch_o_perf_dropped != '1)) fetch_o_perf_dropped <= fetch_o_perf_dropped + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding is ignored by the logic above.
  rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
    !(imem_i_rsp_valid && (out_cnt == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: cycle driver at the falling edge, imem model, decode scoreboard.
module tb_fetch_queue_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        ctrl_i_flush;
  logic [63:0] ctrl_i_redirect_pc;
  logic        fetch_o_imem_req_valid;
  logic        imem_i_req_ready;
  logic [63:0] fetch_o_imem_req_addr;
  logic        imem_i_rsp_valid;
  logic [31:0] imem_i_rsp_data;
  logic        fetch_o_valid;
  logic        decode_i_ready;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_o_perf_fetched;
  logic [31:0] fetch_o_perf_dropped;
`endif

  fetch_queue_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .ctrl_i_flush           (ctrl_i_flush),
    .ctrl_i_redirect_pc     (ctrl_i_redirect_pc),
    .fetch_o_imem_req_valid (fetch_o_imem_req_valid),
    .imem_i_req_ready       (imem_i_req_ready),
    .fetch_o_imem_req_addr  (fetch_o_imem_req_addr),
    .imem_i_rsp_valid       (imem_i_rsp_valid),
    .imem_i_rsp_data        (imem_i_rsp_data),
    .fetch_o_valid          (fetch_o_valid),
    .decode_i_ready         (decode_i_ready),
    .fetch_o_pc             (fetch_o_pc),
    .fetch_o_instr          (fetch_o_instr)
`ifdef FETCH_PERF_EN
    ,
    .fetch_o_perf_fetched   (fetch_o_perf_fetched),
    .fetch_o_perf_dropped   (fetch_o_perf_dropped)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;
  int n_pop_rst = 0;
  logic [63:0] last_pop_pc;

  logic        kn_flush;
  logic [63:0] kn_target;
  logic        kn_req_ready;
  logic        kn_dec_ready;
  logic        rsp_en;
  logic        rsp_force;

  logic [63:0] model_pc;
  logic [63:0] pend_q[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] ifun(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    model_pc  = RST_PC;
    n_pop_rst = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic [63:0] a;
    logic [63:0] e;
    imem_i_req_ready   = kn_req_ready;
    decode_i_ready     = kn_dec_ready;
    ctrl_i_flush       = kn_flush;
    ctrl_i_redirect_pc = kn_target;
    imem_i_rsp_valid   = 1'b0;
    imem_i_rsp_data    = '0;
    if ((rsp_en || rsp_force) && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      imem_i_rsp_valid = 1'b1;
      imem_i_rsp_data  = ifun(a);
    end
    #1;
    if (ctrl_i_flush) begin
      check("flush_req_valid", {63'd0, fetch_o_imem_req_valid}, 64'd0);
      check("flush_fetch_valid", {63'd0, fetch_o_valid}, 64'd0);
    end
    if (fetch_o_imem_req_valid && imem_i_req_ready) begin
      check("req_addr", fetch_o_imem_req_addr, model_pc);
      pend_q.push_back(fetch_o_imem_req_addr);
      exp_q.push_back(model_pc);
      model_pc = model_pc + 64'd4;
      n_acc++;
    end
    if (fetch_o_valid && decode_i_ready) begin
      n_pop++;
      n_pop_rst++;
      last_pop_pc = fetch_o_pc;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", fetch_o_pc, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", fetch_o_pc, e);
        check("dec_instr", {32'd0, fetch_o_instr}, {32'd0, ifun(e)});
      end
    end
    if (ctrl_i_flush) begin
      exp_q.delete();
      model_pc = kn_target & ~64'd3;
    end
    @(negedge clk);
  endtask

  task automatic wait_first_pop(input string tag, input logic [63:0] exp_pc);
    int p0;
    int bud;
    p0  = n_pop;
    bud = 0;
    while (n_pop == p0 && bud < 30) begin
      tick();
      bud++;
    end
    check(tag, (n_pop == p0) ? 64'hFFFF_FFFF_FFFF_FFFF : last_pop_pc, exp_pc);
  endtask

  task automatic accept_n(input string tag, input int n);
    int a0;
    int bud;
    a0  = n_acc;
    bud = 0;
    kn_req_ready = 1'b1;
    while (n_acc - a0 < n && bud < 20) begin
      tick();
      bud++;
    end
    kn_req_ready = 1'b0;
    check(tag, 64'(n_acc - a0), 64'(n));
  endtask

  task automatic drain(input string tag);
    kn_req_ready = 1'b0;
    kn_dec_ready = 1'b1;
    rsp_en       = 1'b1;
    repeat (12) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int a0;
    int p0;
    int bud;
    rst = 1'b0;
    kn_flush = 1'b0; kn_target = '0; kn_req_ready = 1'b0; kn_dec_ready = 1'b0;
    rsp_en = 1'b0; rsp_force = 1'b0;
    ctrl_i_flush = 1'b0; ctrl_i_redirect_pc = '0; imem_i_req_ready = 1'b0;
    imem_i_rsp_valid = 1'b0; imem_i_rsp_data = '0; decode_i_ready = 1'b0;
    last_pop_pc = '0;
    model_reset();
    @(negedge clk); #1;
    check("rst_req_valid", {63'd0, fetch_o_imem_req_valid}, 64'd0);
    check("rst_req_addr", fetch_o_imem_req_addr, RST_PC);
    check("rst_valid", {63'd0, fetch_o_valid}, 64'd0);
    check("rst_pc", fetch_o_pc, 64'd0);
    check("rst_instr", {32'd0, fetch_o_instr}, 64'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", {32'd0, fetch_o_perf_fetched}, 64'd0);
    check("rst_perf_d", {32'd0, fetch_o_perf_dropped}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // T1: sequential fetch at full rate
    kn_req_ready = 1'b1; kn_dec_ready = 1'b1; rsp_en = 1'b1;
    wait_first_pop("t1_first_pc", RST_PC);
    repeat (10) tick();
    p0 = n_pop;
    repeat (10) tick();
    check("t1_rate", 64'(n_pop - p0), 64'd10);

    // T2: decode stalled fills exactly QDEPTH entries
    kn_dec_ready = 1'b0;
    kn_flush = 1'b1; kn_target = 64'h5000;
    tick();
    kn_flush = 1'b0;
    a0 = n_acc;
    repeat (10) tick();
    check("t2_accepted", 64'(n_acc - a0), 64'd4);
    check("t2_req_valid", {63'd0, fetch_o_imem_req_valid}, 64'd0);
    check("t2_fetch_valid", {63'd0, fetch_o_valid}, 64'd1);
    check("t2_head_pc", fetch_o_pc, 64'h5000);
    kn_dec_ready = 1'b1;
    p0 = n_pop; bud = 0;
    while (n_pop - p0 < 4 && bud < 10) begin
      tick();
      bud++;
    end
    check("t2_pops", 64'(n_pop - p0), 64'd4);
    p0 = n_pop;
    repeat (10) tick();
    check("t2_restart", 64'(n_pop - p0 >= 5), 64'd1);

    // T3: flush with 3 outstanding, from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    imem_i_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    rsp_en = 1'b0; kn_dec_ready = 1'b1;
    accept_n("t3_accepted", 3);
    repeat (2) tick();
    check("t3_no_valid", {63'd0, fetch_o_valid}, 64'd0);
    kn_flush = 1'b1; kn_target = 64'h1002; kn_req_ready = 1'b1;
    tick();
    kn_flush = 1'b0;
    check("t3_redirect_addr", fetch_o_imem_req_addr, 64'h1000);
    rsp_en = 1'b1;
    wait_first_pop("t3_first_pc", 64'h1000);
    repeat (8) tick();
    drain("t3_drained");
`ifdef FETCH_PERF_EN
    check("t6_perf_dropped", {32'd0, fetch_o_perf_dropped}, 64'd3);
    check("t6_perf_fetched", {32'd0, fetch_o_perf_fetched}, 64'(n_pop_rst));
`endif

    // T4: flush coinciding with a response, out_cnt=2
    rsp_en = 1'b0;
    accept_n("t4_accepted", 2);
    kn_flush = 1'b1; kn_target = 64'h6000; rsp_force = 1'b1;
    tick();
    kn_flush = 1'b0; rsp_force = 1'b0;
    rsp_en = 1'b1; kn_req_ready = 1'b1;
    wait_first_pop("t4_first_pc", 64'h6000);
    repeat (6) tick();
    kn_flush = 1'b1; kn_target = 64'h7000;
    tick();
    kn_target = 64'h7104;
    tick();
    kn_flush = 1'b0;
    wait_first_pop("t4_b2b_first_pc", 64'h7104);
    repeat (6) tick();
    drain("t4_drained");

    // T5: PC wrap, then asynchronous reset mid-burst
    kn_flush = 1'b1; kn_target = 64'hFFFF_FFFF_FFFF_FFFE; kn_req_ready = 1'b1;
    tick();
    kn_flush = 1'b0;
    a0 = n_acc; bud = 0;
    while (n_acc == a0 && bud < 10) begin
      tick();
      bud++;
    end
    check("t5_wrap_addr", fetch_o_imem_req_addr, 64'd0);
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    check("t5_arst_addr", fetch_o_imem_req_addr, RST_PC);
    check("t5_arst_req_valid", {63'd0, fetch_o_imem_req_valid}, 64'd0);
    check("t5_arst_valid", {63'd0, fetch_o_valid}, 64'd0);
    check("t5_arst_pc", fetch_o_pc, 64'd0);
    @(negedge clk);
    imem_i_rsp_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    kn_req_ready = 1'b1; kn_dec_ready = 1'b1; rsp_en = 1'b1;
    wait_first_pop("t5_after_rst_pc", RST_PC);
    repeat (5) tick();
    drain("t5_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
